// File: rtl/sum_link_pkg.sv
// Shared types and helpers for the inter-core partial-sum exchange link.
package sum_link_pkg;

    localparam int unsigned BW      = 8;
    localparam int unsigned BW_PSUM = 2 * BW + 4;
    localparam int unsigned SUM_W   = BW_PSUM + 4;

    typedef logic [SUM_W-1:0] sum_word_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sum_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is always visible on rdata_o.
module sum_sync_fifo
    import sum_link_pkg::*;
#(
    parameter int unsigned Width = SUM_W,
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = ptr_w(Depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW:0]    count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push while full is dropped even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/sum_link_peer.sv
// Peer endpoint of the partial-sum link: TX FIFO drained by the core, RX register fed by it.
// Optional sticky error flags are built when SUM_LINK_PEER_ERR_EN is defined.
module sum_link_peer
    import sum_link_pkg::*;
#(
    parameter int unsigned bw      = 8,
    parameter int unsigned bw_psum = 2 * bw + 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bw_psum+3:0]   loc_sum,
    input  logic                 loc_wr,
    output logic                 loc_full,
    output logic [bw_psum+3:0]   sum_out,
    output logic                 sum_out_vld,
    input  logic                 ext_rd_in,
    input  logic [bw_psum+3:0]   sum_in,
    input  logic                 sum_rd_vld,
    output logic                 ext_rd_out,
    output logic [bw_psum+3:0]   rx_sum,
    output logic                 rx_vld,
`ifdef SUM_LINK_PEER_ERR_EN
    output logic                 err_ovf,
    output logic                 err_udf,
`endif
    input  logic                 rx_ready
);

    localparam int unsigned W    = bw_psum + 4;
    localparam int unsigned PtrW = ptr_w(DEPTH);

    logic [PtrW:0] tx_count;
    logic          tx_empty;

    sum_sync_fifo #(
        .Width (W),
        .Depth (DEPTH),
        .PtrW  (PtrW)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (loc_wr),
        .wdata_i (loc_sum),
        .pop_i   (ext_rd_in),
        .rdata_o (sum_out),
        .full_o  (loc_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign sum_out_vld = !tx_empty;

    logic [W-1:0] rx_sum_q, rx_sum_d;
    logic         rx_vld_q, rx_vld_d;

    // Gated by reset so the core never sees a pop while the endpoint is held in reset.
    assign ext_rd_out = sum_rd_vld && (!rx_vld_q || rx_ready) && !reset;

    always_comb begin
        rx_sum_d = rx_sum_q;
        rx_vld_d = rx_vld_q;
        if (ext_rd_out) begin
            rx_sum_d = sum_in;
            rx_vld_d = 1'b1;
        end else if (rx_vld_q && rx_ready) begin
            rx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sum_q <= '0;
            rx_vld_q <= 1'b0;
        end else begin
            rx_sum_q <= rx_sum_d;
            rx_vld_q <= rx_vld_d;
        end
    end

    assign rx_sum = rx_sum_q;
    assign rx_vld = rx_vld_q;

`ifdef SUM_LINK_PEER_ERR_EN
    logic err_ovf_q, err_udf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (loc_wr && loc_full) begin
                err_ovf_q <= 1'b1;
            end
            if (ext_rd_in && !sum_out_vld) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule
